// File: rtl/lab2_proc_imul_arbiter.sv
// Arbitrates N requesters onto one shared variable-latency multiplier, one transaction in flight.
// Define LAB2_PROC_IMUL_ARB_RR_EN for round-robin arbitration; the default is fixed priority (lowest index wins).
module lab2_proc_imul_arbiter #(
    parameter int p_num_reqs  = 4,
    parameter int p_ptr_nbits = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [p_num_reqs-1:0]     req_val,
    output logic [p_num_reqs-1:0]     req_rdy,
    input  logic [64*p_num_reqs-1:0]  req_msg,
    output logic [p_num_reqs-1:0]     resp_val,
    input  logic [p_num_reqs-1:0]     resp_rdy,
    output logic [31:0]               resp_msg,
    output logic                      mul_req_val,
    input  logic                      mul_req_rdy,
    output logic [63:0]               mul_req_msg,
    input  logic                      mul_resp_val,
    output logic                      mul_resp_rdy,
    input  logic [31:0]               mul_resp_msg,
    output logic [p_ptr_nbits-1:0]    owner
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                   r_state;
    logic [p_ptr_nbits-1:0]   r_owner;
    logic [p_ptr_nbits-1:0]   w_winner;
    logic                     w_any;
`ifdef LAB2_PROC_IMUL_ARB_RR_EN
    logic [p_ptr_nbits-1:0]   r_ptr;
`endif

    assign w_any = |req_val;
    assign owner = r_owner;

    // Winner select: scanning from the lowest-priority slot upward leaves the highest-priority hit.
    always_comb begin
        w_winner = {p_ptr_nbits{1'b0}};
`ifdef LAB2_PROC_IMUL_ARB_RR_EN
        for (int i = p_num_reqs - 1; i >= 0; i--) begin
            w_winner = req_val[(int'(r_ptr) + i) % p_num_reqs]
                     ? p_ptr_nbits'((int'(r_ptr) + i) % p_num_reqs)
                     : w_winner;
        end
`else
        for (int i = p_num_reqs - 1; i >= 0; i--) begin
            w_winner = req_val[i] ? p_ptr_nbits'(i) : w_winner;
        end
`endif
    end

    // Handshake steering; everything is forced quiet while reset is held.
    always_comb begin
        req_rdy      = {p_num_reqs{1'b0}};
        resp_val     = {p_num_reqs{1'b0}};
        resp_msg     = 32'd0;
        mul_req_val  = 1'b0;
        mul_req_msg  = 64'd0;
        mul_resp_rdy = 1'b0;
        if (reset) begin
            case (r_state)
                IDLE: begin
                    mul_req_val       = w_any;
                    mul_req_msg       = w_any ? req_msg[int'(w_winner)*64 +: 64] : 64'd0;
                    req_rdy[w_winner] = mul_req_rdy & w_any;
                end
                BUSY: begin
                    resp_val[r_owner] = mul_resp_val;
                    mul_resp_rdy      = resp_rdy[r_owner];
                    resp_msg          = mul_resp_msg;
                end
                default: begin
                    mul_req_val = 1'b0;
                end
            endcase
        end else begin
            req_rdy = {p_num_reqs{1'b0}};
        end
    end

    // State, owner and priority pointer update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_owner <= {p_ptr_nbits{1'b0}};
`ifdef LAB2_PROC_IMUL_ARB_RR_EN
            r_ptr   <= {p_ptr_nbits{1'b0}};
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any && mul_req_rdy) begin
                        r_owner <= w_winner;
                        r_state <= BUSY;
`ifdef LAB2_PROC_IMUL_ARB_RR_EN
                        r_ptr   <= (w_winner == p_ptr_nbits'(p_num_reqs - 1))
                                 ? {p_ptr_nbits{1'b0}}
                                 : w_winner + p_ptr_nbits'(1'b1);
`endif
                    end
                end
                BUSY: begin
                    if (mul_resp_val && resp_rdy[r_owner]) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
